lsu_bus: RTL and testbench

LSU_BUS -- requirements
Module: lsu_bus

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_align.sv | 60 ++++++
 rtl/lsu_bus.sv | 161 ++++++++++++++++
 tb/tb_lsu_bus.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store bus adapter.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Bytes covered by an access of the given size encoding.
    function automatic int unsigned size_bytes(input logic [1:0] size);
        return 32'd1 << size;
    endfunction

    // Right-aligned data mask for an access of the given size encoding.
    function automatic logic [63:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 64'h0000_0000_0000_00FF;
            SZ_H:    return 64'h0000_0000_0000_FFFF;
            SZ_W:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational store lane placement/strobes and load extraction/extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [31:0]                   st_addr,
    input  logic [1:0]                    st_size,
    input  logic [DATA_W-1:0]             st_wdata,
    output logic [1:0]                    size_c,
    output logic [31:0]                   mem_addr_c,
    output logic [DATA_W-1:0]             wdata_c,
    output logic [DATA_W/8-1:0]           wstrb_c,
    output logic [$clog2(DATA_W/8)-1:0]   lane_c,
    output logic                          misalign_c,
    input  logic [$clog2(DATA_W/8)-1:0]   ld_lane,
    input  logic [1:0]                    ld_size,
    input  logic                          ld_unsigned,
    input  logic [DATA_W-1:0]             ld_rdata,
    output logic [DATA_W-1:0]             ld_data_c
);

    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned LB = $clog2(NB);

    logic [LB-1:0]     lo_mask;
    logic [DATA_W-1:0] st_mask;
    logic [DATA_W-1:0] ld_shift;
    logic [DATA_W-1:0] ld_mask;
    logic              ld_sign;

    // Store side: a doubleword on a 32-bit bus degrades to a word access.
    always_comb begin
        size_c = st_size;
        if (DATA_W == 32 && st_size == SZ_D) begin
            size_c = SZ_W;
        end
        lo_mask    = LB'(size_bytes(size_c) - 32'd1);
        misalign_c = (st_addr[LB-1:0] & lo_mask) != '0;
        lane_c     = st_addr[LB-1:0] & ~lo_mask;
        mem_addr_c = {st_addr[31:LB], LB'(0)};
        st_mask    = DATA_W'(size_mask(size_c));
        wdata_c    = (st_wdata & st_mask) << {lane_c, 3'b000};
        wstrb_c    = NB'((64'd1 << size_bytes(size_c)) - 64'd1) << lane_c;
    end

    // Load side: shift the addressed lane down, then sign- or zero-extend.
    always_comb begin
        ld_shift = ld_rdata >> {ld_lane, 3'b000};
        ld_mask  = DATA_W'(size_mask(ld_size));
        case (ld_size)
            SZ_B:    ld_sign = ld_shift[7];
            SZ_H:    ld_sign = ld_shift[15];
            SZ_W:    ld_sign = ld_shift[31];
            default: ld_sign = ld_shift[DATA_W-1];
        endcase
        ld_data_c = (ld_shift & ld_mask) | ((ld_sign & ~ld_unsigned) ? ~ld_mask : '0);
    end

endmodule

// File: rtl/lsu_bus.sv
// Single-outstanding load/store adapter from a valid/ready request port to a simple memory bus.
// Optional: define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of issuing them aligned down.
module lsu_bus
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REST_W = 40
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_addr,
    input  logic                  in_ren,
    input  logic                  in_wen,
    input  logic [2:0]            in_op,
    input  logic [DATA_W-1:0]     in_wdata,
    input  logic [REST_W-1:0]     in_rest,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_rdata,
    output logic [REST_W-1:0]     out_rest,
    output logic                  out_fault,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_wen,
    output logic [31:0]           mem_req_addr,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [DATA_W/8-1:0]   mem_req_wstrb,
    input  logic                  mem_resp_valid,
    input  logic [DATA_W-1:0]     mem_resp_rdata,
    input  logic                  mem_resp_err
);

    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned LB = $clog2(NB);

    lsu_state_e        state_q, state_d;

    logic [1:0]        size_c;
    logic [31:0]       mem_addr_c;
    logic [DATA_W-1:0] wdata_c;
    logic [NB-1:0]     wstrb_c;
    logic [LB-1:0]     lane_c;
    logic              misalign_c;
    logic [DATA_W-1:0] ld_data_c;

    logic [LB-1:0]     ld_lane_q;
    logic [1:0]        ld_size_q;
    logic              ld_unsigned_q;

    logic              accept_c;
    logic              is_access_c;
    logic              is_store_c;
    logic              trap_c;
    logic              go_req_c;

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .st_addr     (in_addr),
        .st_size     (in_op[1:0]),
        .st_wdata    (in_wdata),
        .size_c      (size_c),
        .mem_addr_c  (mem_addr_c),
        .wdata_c     (wdata_c),
        .wstrb_c     (wstrb_c),
        .lane_c      (lane_c),
        .misalign_c  (misalign_c),
        .ld_lane     (ld_lane_q),
        .ld_size     (ld_size_q),
        .ld_unsigned (ld_unsigned_q),
        .ld_rdata    (mem_resp_rdata),
        .ld_data_c   (ld_data_c)
    );

    // A request with both enables set is a load; only a pure store writes.
    assign is_access_c = in_ren | in_wen;
    assign is_store_c  = in_wen & ~in_ren;
`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_c      = is_access_c & misalign_c;
`else
    assign trap_c      = 1'b0;
`endif
    assign go_req_c    = is_access_c & ~trap_c;
    assign accept_c    = in_valid & in_ready;

    assign mem_req_valid = (state_q == REQ);
    assign out_valid     = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = go_req_c ? REQ : DONE;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = mem_req_wen ? DONE : RESP;
                end
            end
            RESP: begin
                if (mem_resp_valid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        state_d = go_req_c ? REQ : DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request fields are frozen at capture so they stay stable through a bus stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_wen   <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wstrb <= '0;
            ld_lane_q     <= '0;
            ld_size_q     <= SZ_B;
            ld_unsigned_q <= 1'b0;
            out_rdata     <= '0;
            out_rest      <= '0;
            out_fault     <= 1'b0;
        end else if (accept_c) begin
            mem_req_wen   <= is_store_c;
            mem_req_addr  <= mem_addr_c;
            mem_req_wdata <= is_store_c ? wdata_c : '0;
            mem_req_wstrb <= is_store_c ? wstrb_c : '0;
            ld_lane_q     <= lane_c;
            ld_size_q     <= size_c;
            ld_unsigned_q <= in_op[2];
            out_rdata     <= '0;
            out_rest      <= in_rest;
            out_fault     <= trap_c;
        end else if (state_q == RESP && mem_resp_valid) begin
            out_rdata     <= ld_data_c;
            out_fault     <= mem_resp_err;
        end
    end

endmodule

// File: tb/tb_lsu_bus.sv
// Self-checking bench for lsu_bus (DATA_W=32): vector table plus stall, hold and reset sequences.
module tb_lsu_bus;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic        in_ren;
    logic        in_wen;
    logic [2:0]  in_op;
    logic [31:0] in_wdata;
    logic [39:0] in_rest;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic [39:0] out_rest;
    logic        out_fault;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        mem_resp_err;

    lsu_bus #(.DATA_W(32), .REST_W(40)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_addr        (in_addr),
        .in_ren         (in_ren),
        .in_wen         (in_wen),
        .in_op          (in_op),
        .in_wdata       (in_wdata),
        .in_rest        (in_rest),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_rdata      (out_rdata),
        .out_rest       (out_rest),
        .out_fault      (out_fault),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_wen    (mem_req_wen),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wstrb  (mem_req_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .mem_resp_err   (mem_resp_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic        ren;
        logic        wen;
        logic [2:0]  op;
        logic [31:0] wdata;
        logic [31:0] word;
        logic        err;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        logic        exp_mem;
        logic [31:0] exp_maddr;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_mwdata;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic [39:0] rest;
        logic        fault;
    } oexp_t;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mexp_t;

    oexp_t out_q[$];
    mexp_t mem_q[$];
    vec_t  vecs[12];

    int          checks = 0;
    int          errors = 0;
    int          mem_hs = 0;
    logic [31:0] rsp_word = '0;
    logic        rsp_err = 1'b0;
    logic        rsp_pend = 1'b0;
    logic        hold_resp = 1'b0;
    logic        stray = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input logic ren, input logic wen,
                                input logic [2:0] op, input logic [31:0] wdata,
                                input logic [31:0] word, input logic err,
                                input logic [31:0] exp_rdata, input logic exp_fault,
                                input logic exp_mem, input logic [31:0] exp_maddr,
                                input logic [3:0] exp_wstrb, input logic [31:0] exp_mwdata);
        vec_t v;
        v.addr = addr; v.ren = ren; v.wen = wen; v.op = op; v.wdata = wdata;
        v.word = word; v.err = err; v.exp_rdata = exp_rdata; v.exp_fault = exp_fault;
        v.exp_mem = exp_mem; v.exp_maddr = exp_maddr; v.exp_wstrb = exp_wstrb;
        v.exp_mwdata = exp_mwdata;
        return v;
    endfunction

    // Result scoreboard: compare every accepted result against the queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (out_q.size() == 0) begin
                chk("unexpected_out", 64'd1, 64'd0);
            end else begin
                oexp_t o;
                o = out_q.pop_front();
                chk("out_rdata", 64'(out_rdata), 64'(o.rdata));
                chk("out_rest",  64'(out_rest),  64'(o.rest));
                chk("out_fault", 64'(out_fault), 64'(o.fault));
            end
        end
    end

    // Memory model: checks request handshakes and returns a response one cycle later.
    always @(negedge clk) begin
        if (rsp_pend) begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = rsp_word;
            mem_resp_err   = rsp_err;
            rsp_pend       = 1'b0;
        end else if (stray) begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = 32'hDEAD_0001;
            mem_resp_err   = 1'b1;
            stray          = 1'b0;
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_rdata = '0;
            mem_resp_err   = 1'b0;
        end
        if (rst_n && mem_req_valid && mem_req_ready) begin
            mem_hs++;
            if (mem_q.size() == 0) begin
                chk("unexpected_mem_req", 64'd1, 64'd0);
            end else begin
                mexp_t m;
                m = mem_q.pop_front();
                chk("mem_req_wen",   64'(mem_req_wen),   64'(m.wen));
                chk("mem_req_addr",  64'(mem_req_addr),  64'(m.addr));
                chk("mem_req_wstrb", 64'(mem_req_wstrb), 64'(m.wstrb));
                if (m.wen) chk("mem_req_wdata", 64'(mem_req_wdata), 64'(m.wdata));
            end
            if (!mem_req_wen && !hold_resp) rsp_pend = 1'b1;
        end
    end

    // Queue expectations, then present the request until it is accepted.
    task automatic send(input vec_t v, input logic [39:0] rest, input logic sync, output int waits);
        oexp_t o;
        mexp_t m;
        logic  acc;
        if (sync) begin
            @(posedge clk);
            #1;
        end
        o.rdata = v.exp_rdata;
        o.rest  = rest;
        o.fault = v.exp_fault;
        out_q.push_back(o);
        if (v.exp_mem) begin
            m.wen   = v.wen & ~v.ren;
            m.addr  = v.exp_maddr;
            m.wdata = v.exp_mwdata;
            m.wstrb = v.exp_wstrb;
            mem_q.push_back(m);
        end
        rsp_word = v.word;
        rsp_err  = v.err;
        in_addr  = v.addr;
        in_ren   = v.ren;
        in_wen   = v.wen;
        in_op    = v.op;
        in_wdata = v.wdata;
        in_rest  = rest;
        in_valid = 1'b1;
        waits    = 0;
        acc      = 1'b0;
        while (!acc && waits < 50) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            else waits++;
        end
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_ren   = 1'b0;
        in_wen   = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((out_q.size() != 0 || mem_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(out_q.size() + mem_q.size()), 64'd0);
    endtask

    initial begin
        int          w;
        int          n;
        int          hs0;
        logic [39:0] rest;
        vec_t        v;

        rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_ren = 1'b0; in_wen = 1'b0;
        in_op = '0; in_wdata = '0; in_rest = '0; out_ready = 1'b1; mem_req_ready = 1'b1;
        mem_resp_valid = 1'b0; mem_resp_rdata = '0; mem_resp_err = 1'b0;

        //            addr          ren  wen  op    wdata         word          err  rdata         flt  mem  maddr         strb     mwdata
        vecs[0]  = mk(32'h8000_0003, 1, 0, 3'b000, 32'h0,        32'h80FF_0000, 0, 32'hFFFF_FF80, 0, 1, 32'h8000_0000, 4'b0000, 32'h0);
        vecs[1]  = mk(32'h8000_0003, 1, 0, 3'b100, 32'h0,        32'h80FF_0000, 0, 32'h0000_0080, 0, 1, 32'h8000_0000, 4'b0000, 32'h0);
        vecs[2]  = mk(32'h8000_0002, 1, 0, 3'b001, 32'h0,        32'h80FF_0000, 0, 32'hFFFF_80FF, 0, 1, 32'h8000_0000, 4'b0000, 32'h0);
        vecs[3]  = mk(32'h8000_0000, 1, 0, 3'b101, 32'h0,        32'h1234_ABCD, 0, 32'h0000_ABCD, 0, 1, 32'h8000_0000, 4'b0000, 32'h0);
        vecs[4]  = mk(32'h8000_0004, 1, 0, 3'b010, 32'h0,        32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 1, 32'h8000_0004, 4'b0000, 32'h0);
        vecs[5]  = mk(32'h8000_0002, 0, 1, 3'b001, 32'h0000_1234, 32'h0,        0, 32'h0,         0, 1, 32'h8000_0000, 4'b1100, 32'h1234_0000);
        vecs[6]  = mk(32'h8000_0001, 0, 1, 3'b000, 32'h0000_00A5, 32'h0,        0, 32'h0,         0, 1, 32'h8000_0000, 4'b0010, 32'h0000_A500);
        vecs[7]  = mk(32'h8000_0008, 0, 1, 3'b010, 32'hCAFE_F00D, 32'h0,        0, 32'h0,         0, 1, 32'h8000_0008, 4'b1111, 32'hCAFE_F00D);
        vecs[8]  = mk(32'h8000_0010, 0, 0, 3'b010, 32'h5555_5555, 32'h0,        0, 32'h0,         0, 0, 32'h0,         4'b0000, 32'h0);
        vecs[9]  = mk(32'h8000_0002, 1, 1, 3'b001, 32'hFFFF_FFFF, 32'h7FFF_0000, 0, 32'h0000_7FFF, 0, 1, 32'h8000_0000, 4'b0000, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[10] = mk(32'h8000_0002, 1, 0, 3'b010, 32'h0,        32'h1122_3344, 0, 32'h0,         1, 0, 32'h0,         4'b0000, 32'h0);
`else
        vecs[10] = mk(32'h8000_0002, 1, 0, 3'b010, 32'h0,        32'h1122_3344, 0, 32'h1122_3344, 0, 1, 32'h8000_0000, 4'b0000, 32'h0);
`endif
        vecs[11] = mk(32'h8000_0000, 1, 0, 3'b000, 32'h0,        32'h0000_00FF, 1, 32'hFFFF_FFFF, 1, 1, 32'h8000_0000, 4'b0000, 32'h0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(in_ready),      64'd1);
        chk("rst_out_valid", 64'(out_valid),     64'd0);
        chk("rst_mem_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_out_rdata", 64'(out_rdata),     64'd0);
        chk("rst_out_fault", 64'(out_fault),     64'd0);
        rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < 12; i++) begin
            rest = {8'($urandom), 32'($urandom)};
            send(vecs[i], rest, 1'b1, w);
            wait_idle();
        end

        // Memory request stall: fields held, nothing accepted or produced
        mem_req_ready = 1'b0;
        rest = 40'h12_3456_789A;
        send(vecs[5], rest, 1'b1, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_mem_valid", 64'(mem_req_valid), 64'd1);
            chk("stall_mem_addr",  64'(mem_req_addr),  64'h8000_0000);
            chk("stall_mem_wstrb", 64'(mem_req_wstrb), 64'hC);
            chk("stall_mem_wdata", 64'(mem_req_wdata), 64'h1234_0000);
            chk("stall_in_ready",  64'(in_ready),      64'd0);
            chk("stall_out_valid", 64'(out_valid),     64'd0);
        end
        @(posedge clk);
        #1;
        mem_req_ready = 1'b1;
        wait_idle();

        // Output back-pressure, then same-cycle acceptance of the next request
        out_ready = 1'b0;
        rest = 40'hAB_CDEF_0123;
        send(vecs[0], rest, 1'b1, w);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reach_done", 64'(out_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_out_rdata", 64'(out_rdata), 64'hFFFF_FF80);
            chk("hold_out_rest",  64'(out_rest),  64'hAB_CDEF_0123);
            chk("hold_out_fault", 64'(out_fault), 64'd0);
            chk("hold_in_ready",  64'(in_ready),  64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(vecs[3], 40'h00_0000_0042, 1'b0, w);
        chk("same_cycle_accept", 64'(w), 64'd0);
        wait_idle();

        // Reset while waiting for a read response; the late response is dropped
        hold_resp = 1'b1;
        hs0 = mem_hs;
        send(vecs[4], 40'hFF_FFFF_FFFF, 1'b1, w);
        n = 0;
        while (mem_hs == hs0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("abort_mem_hs", 64'(mem_hs - hs0), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready",  64'(in_ready),      64'd1);
        chk("abort_out_valid", 64'(out_valid),     64'd0);
        chk("abort_mem_valid", 64'(mem_req_valid), 64'd0);
        chk("abort_out_rest",  64'(out_rest),      64'd0);
        chk("abort_out_rdata", 64'(out_rdata),     64'd0);
        chk("abort_out_fault", 64'(out_fault),     64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_q.delete();
        hold_resp = 1'b0;
        stray = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("late_out_valid", 64'(out_valid), 64'd0);
            chk("late_in_ready",  64'(in_ready),  64'd1);
        end
        v = vecs[2];
        send(v, 40'h01_0203_0405, 1'b1, w);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1);
    end

endmodule
